// File: rtl/meat_cook_fsm_pkg.sv
// Shared stage codes, slot states and colour constants for the per-steak cooking controller.
package meat_cook_fsm_pkg;

  typedef enum logic [2:0] {
    RAW    = 3'd0,
    RARE   = 3'd1,
    MEDIUM = 3'd2,
    WELL   = 3'd3,
    BURNT  = 3'd4
  } stage_e;

  typedef enum logic {
    EMPTY   = 1'b0,
    COOKING = 1'b1
  } state_e;

  // Colours are {R[2:0],G[2:0],B[2:0]}
  localparam logic [8:0] MUSCLE_RAW    = 9'b111_000_000;
  localparam logic [8:0] FAT_RAW       = 9'b111_111_111;
  localparam logic [8:0] MUSCLE_RARE   = 9'b110_001_001;
  localparam logic [8:0] FAT_RARE      = 9'b111_111_110;
  localparam logic [8:0] MUSCLE_MEDIUM = 9'b100_010_001;
  localparam logic [8:0] FAT_MEDIUM    = 9'b111_110_100;
  localparam logic [8:0] MUSCLE_WELL   = 9'b011_010_001;
  localparam logic [8:0] FAT_WELL      = 9'b110_100_010;
  localparam logic [8:0] MUSCLE_BURNT  = 9'b001_001_001;
  localparam logic [8:0] FAT_BURNT     = 9'b010_010_010;

  function automatic stage_e stage_next(input stage_e s);
    case (s)
      RAW:     return RARE;
      RARE:    return MEDIUM;
      MEDIUM:  return WELL;
      default: return BURNT;
    endcase
  endfunction

  function automatic logic stage_ok(input stage_e s);
    return (s == MEDIUM) || (s == WELL);
  endfunction

endpackage

// File: rtl/meat_cook_fsm_if.sv
// Control/score/colour signals between the grill-slot controller and its surroundings.
interface meat_cook_fsm_if;
  logic       start;
  logic       flip;
  logic       serve;
  logic [8:0] colour_fat;
  logic [8:0] colour_muscle;
  logic       score_good;
  logic       score_bad;
  logic       occupied;
  logic       burnt;

  modport master (
    output start, flip, serve,
    input  colour_fat, colour_muscle, score_good, score_bad, occupied, burnt
  );

  modport slave (
    input  start, flip, serve,
    output colour_fat, colour_muscle, score_good, score_bad, occupied, burnt
  );
endinterface

// File: rtl/meat_cook_fsm_stage_timer.sv
// Free-running stage tick counter with synchronous clear and a terminal-count pulse.
module meat_cook_fsm_stage_timer #(
  parameter int unsigned TICKS_PER_STAGE = 150000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (TICKS_PER_STAGE > 1) ? $clog2(TICKS_PER_STAGE) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TICKS_PER_STAGE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/meat_cook_fsm.sv
// Grill-slot controller: cooks the down side of one steak, shows the up side, scores on serve.
module meat_cook_fsm
  import meat_cook_fsm_pkg::*;
#(
  parameter int unsigned TICKS_PER_STAGE = 150000000
) (
  input  logic                 clk,
  input  logic                 resetn,
  meat_cook_fsm_if.slave       bus
);

  state_e     state_q, state_d;
  stage_e     stage_a_q, stage_a_d;
  stage_e     stage_b_q, stage_b_d;
  logic       side_down_q, side_down_d;
  logic       tmr_clr, tmr_en, tmr_tc;

  logic [8:0] colour_fat_q, colour_fat_d;
  logic [8:0] colour_muscle_q, colour_muscle_d;
  logic       score_good_q, score_good_d;
  logic       score_bad_q, score_bad_d;
  logic       occupied_q, occupied_d;
  logic       burnt_q, burnt_d;
  stage_e     stage_up;

  meat_cook_fsm_stage_timer #(
    .TICKS_PER_STAGE(TICKS_PER_STAGE)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .tc_o   (tmr_tc)
  );

  // Serve beats flip beats the terminal-count advance
  always_comb begin
    state_d      = state_q;
    stage_a_d    = stage_a_q;
    stage_b_d    = stage_b_q;
    side_down_d  = side_down_q;
    tmr_clr      = 1'b1;
    tmr_en       = 1'b0;
    score_good_d = 1'b0;
    score_bad_d  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (bus.start) begin
          state_d     = COOKING;
          stage_a_d   = RAW;
          stage_b_d   = RAW;
          side_down_d = 1'b0;
        end
      end
      COOKING: begin
        tmr_en  = 1'b1;
        tmr_clr = 1'b0;
        if (bus.serve) begin
          state_d      = EMPTY;
          stage_a_d    = RAW;
          stage_b_d    = RAW;
          side_down_d  = 1'b0;
          tmr_clr      = 1'b1;
          score_good_d = stage_ok(stage_a_q) && stage_ok(stage_b_q);
          score_bad_d  = !(stage_ok(stage_a_q) && stage_ok(stage_b_q));
        end else if (bus.flip) begin
          side_down_d = !side_down_q;
          tmr_clr     = 1'b1;
        end else if (tmr_tc) begin
          if (side_down_q)
            stage_b_d = stage_next(stage_b_q);
          else
            stage_a_d = stage_next(stage_a_q);
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    stage_up        = side_down_q ? stage_a_q : stage_b_q;
    colour_fat_d    = '0;
    colour_muscle_d = '0;
    if (state_q == COOKING) begin
      case (stage_up)
        RAW:    begin colour_muscle_d = MUSCLE_RAW;    colour_fat_d = FAT_RAW;    end
        RARE:   begin colour_muscle_d = MUSCLE_RARE;   colour_fat_d = FAT_RARE;   end
        MEDIUM: begin colour_muscle_d = MUSCLE_MEDIUM; colour_fat_d = FAT_MEDIUM; end
        WELL:   begin colour_muscle_d = MUSCLE_WELL;   colour_fat_d = FAT_WELL;   end
        default: begin colour_muscle_d = MUSCLE_BURNT; colour_fat_d = FAT_BURNT;  end
      endcase
    end
    occupied_d = (state_q == COOKING);
    burnt_d    = (state_q == COOKING) && ((stage_a_q == BURNT) || (stage_b_q == BURNT));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= EMPTY;
      stage_a_q       <= RAW;
      stage_b_q       <= RAW;
      side_down_q     <= 1'b0;
      colour_fat_q    <= '0;
      colour_muscle_q <= '0;
      score_good_q    <= 1'b0;
      score_bad_q     <= 1'b0;
      occupied_q      <= 1'b0;
      burnt_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      stage_a_q       <= stage_a_d;
      stage_b_q       <= stage_b_d;
      side_down_q     <= side_down_d;
      colour_fat_q    <= colour_fat_d;
      colour_muscle_q <= colour_muscle_d;
      score_good_q    <= score_good_d;
      score_bad_q     <= score_bad_d;
      occupied_q      <= occupied_d;
      burnt_q         <= burnt_d;
    end
  end

  assign bus.colour_fat    = colour_fat_q;
  assign bus.colour_muscle = colour_muscle_q;
  assign bus.score_good    = score_good_q;
  assign bus.score_bad     = score_bad_q;
  assign bus.occupied      = occupied_q;
  assign bus.burnt         = burnt_q;

endmodule

// File: tb/tb_meat_cook_fsm.sv
// Directed bench for the grill-slot controller with a 4-cycle doneness stage.
module tb_meat_cook_fsm;

  localparam logic [8:0] M_RAW   = 9'b111_000_000;
  localparam logic [8:0] F_RAW   = 9'b111_111_111;
  localparam logic [8:0] M_MED   = 9'b100_010_001;
  localparam logic [8:0] F_MED   = 9'b111_110_100;
  localparam logic [8:0] M_BURNT = 9'b001_001_001;
  localparam logic [8:0] F_BURNT = 9'b010_010_010;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  meat_cook_fsm_if bus ();

  meat_cook_fsm #(
    .TICKS_PER_STAGE(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // {occupied, burnt, score_good, score_bad, colour_muscle, colour_fat}
  logic [21:0] obs;
  assign obs = {bus.occupied, bus.burnt, bus.score_good, bus.score_bad,
                bus.colour_muscle, bus.colour_fat};

  task automatic cycle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_on();
    bus.start = 1'b1;
    cycle(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_flip();
    bus.flip = 1'b1;
    cycle(1);
    bus.flip = 1'b0;
  endtask

  task automatic pulse_serve();
    bus.serve = 1'b1;
    cycle(1);
    bus.serve = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] exp;
    resetn = 1'b0;
    bus.start = 1'b0; bus.flip = 1'b0; bus.serve = 1'b0;
    cycle(2);
    exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_state got %h exp %h", obs, exp); end
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(1);
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL idle[%0d] got %h exp %h", i, obs, exp); end
    end
    put_on();
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL start_latency1 got %h exp %h", obs, exp); end
    cycle(1);
    exp = {4'b1000, M_RAW, F_RAW};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL start_latency2 got %h exp %h", obs, exp); end
    pulse_serve();
    cycle(1);
  endtask

  task automatic test_flip_colour();
    logic [21:0] exp;
    put_on();
    cycle(8);
    exp = {4'b1000, M_RAW, F_RAW};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL a_medium_b_up got %h exp %h", obs, exp); end
    pulse_flip();
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL flip_latency1 got %h exp %h", obs, exp); end
    cycle(1);
    exp = {4'b1000, M_MED, F_MED};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL flip_shows_a got %h exp %h", obs, exp); end
    pulse_serve();
    exp = {4'b1001, M_MED, F_MED};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL serve_half_raw got %h exp %h", obs, exp); end
    cycle(1);
    exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL serve_half_raw_after got %h exp %h", obs, exp); end
  endtask

  task automatic test_serve_good();
    logic [21:0] exp;
    put_on();
    cycle(8);
    pulse_flip();
    cycle(8);
    pulse_serve();
    exp = {4'b1010, M_MED, F_MED};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL serve_good got %h exp %h", obs, exp); end
    cycle(1);
    exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL serve_good_after got %h exp %h", obs, exp); end
  endtask

  task automatic test_serve_early();
    logic [21:0] exp;
    put_on();
    cycle(2);
    pulse_serve();
    exp = {4'b1001, M_RAW, F_RAW};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL serve_raw got %h exp %h", obs, exp); end
    cycle(1);
    exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL serve_raw_after got %h exp %h", obs, exp); end
    pulse_flip();
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL empty_flip got %h exp %h", obs, exp); end
    pulse_serve();
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL empty_serve got %h exp %h", obs, exp); end
    cycle(1);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL empty_serve_after got %h exp %h", obs, exp); end
  endtask

  task automatic test_burnt();
    logic [21:0] exp;
    put_on();
    cycle(16);
    exp = {4'b1000, M_RAW, F_RAW};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL burnt_edge_before got %h exp %h", obs, exp); end
    cycle(1);
    exp = {4'b1100, M_RAW, F_RAW};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL burnt_edge got %h exp %h", obs, exp); end
    cycle(3);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL burnt_saturate got %h exp %h", obs, exp); end
    pulse_flip();
    cycle(1);
    exp = {4'b1100, M_BURNT, F_BURNT};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL burnt_colour got %h exp %h", obs, exp); end
    pulse_serve();
    exp = {4'b1101, M_BURNT, F_BURNT};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL burnt_serve got %h exp %h", obs, exp); end
    cycle(1);
    exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL burnt_serve_after got %h exp %h", obs, exp); end
  endtask

  task automatic test_flip_clears_counter();
    logic [21:0] exp;
    put_on();
    cycle(2);
    pulse_flip();
    cycle(2);
    pulse_flip();
    cycle(1);
    exp = {4'b1000, M_RAW, F_RAW};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL flip_clears_cnt got %h exp %h", obs, exp); end
    pulse_serve();
    cycle(1);
  endtask

  task automatic test_flip_on_tc();
    logic [21:0] exp;
    put_on();
    cycle(3);
    pulse_flip();
    cycle(1);
    exp = {4'b1000, M_RAW, F_RAW};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL flip_on_tc got %h exp %h", obs, exp); end
    bus.serve = 1'b1;
    bus.flip  = 1'b1;
    cycle(1);
    bus.serve = 1'b0;
    bus.flip  = 1'b0;
    exp = {4'b1001, M_RAW, F_RAW};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL serve_and_flip got %h exp %h", obs, exp); end
    cycle(1);
    exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL serve_and_flip_after got %h exp %h", obs, exp); end
  endtask

  task automatic test_reset_midcook();
    logic [21:0] exp;
    put_on();
    cycle(5);
    resetn    = 1'b0;
    bus.serve = 1'b1;
    cycle(1);
    exp = '0;
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_midcook got %h exp %h", obs, exp); end
    bus.serve = 1'b0;
    resetn    = 1'b1;
    cycle(2);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_midcook_after got %h exp %h", obs, exp); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.flip  = 1'b0;
    bus.serve = 1'b0;
    test_reset();
    test_flip_colour();
    test_serve_good();
    test_serve_early();
    test_burnt();
    test_flip_clears_counter();
    test_flip_on_tc();
    test_reset_midcook();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
